// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: drives the shared ALU/memory datapath phase by phase.
// Optional trap on unsupported opcodes is enabled by defining MULTICYCLE_CTRL_TRAP_EN.
module multicycle_ctrl (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       i_or_d_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic [1:0] pc_source_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic       reg_write_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       retire_o,
   output logic [3:0] state_o,
   output logic       illegal_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      I_EXEC   = 4'd10,
      I_WB     = 4'd11,
      JR       = 4'd12,
      TRAP     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   state_t state_q, state_d;
`ifdef MULTICYCLE_CTRL_TRAP_EN
   logic illegal_c;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      i_or_d_o     = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_source_o  = 2'b00;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      reg_write_o  = 1'b0;
      reg_dst_o    = 2'b00;
      mem_to_reg_o = 2'b00;
      retire_o     = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      illegal_c    = 1'b0;
`endif
      case (state_q)
         FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = DECODE;
            end
         end
         DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            alu_src_b_o = 2'b11;
            case (opcode_i)
               OP_LW, OP_SW:   state_d = MEM_ADDR;
               OP_RTYPE:       state_d = (funct_i == FN_JR) ? JR : R_EXEC;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_J, OP_JAL:   state_d = JUMP;
               OP_ADDI:        state_d = I_EXEC;
               default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                  state_d = TRAP;
`else
                  state_d  = FETCH;
                  retire_o = 1'b1;
`endif
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
            if (mem_ready_i) state_d = MEM_WB;
         end
         MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 2'b01;
            retire_o     = 1'b1;
            state_d      = FETCH;
         end
         MEM_WR: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
            if (mem_ready_i) begin
               retire_o = 1'b1;
               state_d  = FETCH;
            end
         end
         R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b010;
            state_d     = R_WB;
         end
         R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 2'b01;
            retire_o    = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b001;
            pc_source_o = 2'b01;
            pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
            retire_o    = 1'b1;
            state_d     = FETCH;
         end
         JUMP: begin
            pc_write_o  = 1'b1;
            pc_source_o = 2'b10;
            if (opcode_i == OP_JAL) begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'b10;
               mem_to_reg_o = 2'b10;
            end
            retire_o = 1'b1;
            state_d  = FETCH;
         end
         I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = I_WB;
         end
         I_WB: begin
            reg_write_o = 1'b1;
            retire_o    = 1'b1;
            state_d     = FETCH;
         end
         JR: begin
            pc_write_o  = 1'b1;
            pc_source_o = 2'b11;
            retire_o    = 1'b1;
            state_d     = FETCH;
         end
`ifdef MULTICYCLE_CTRL_TRAP_EN
         TRAP: begin
            illegal_c = 1'b1;
            state_d   = TRAP;
         end
`endif
         default: state_d = FETCH;
      endcase
      // Reset overrides every output so no write enable can fire in the reset cycle.
      if (rst_i) begin
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         i_or_d_o     = 1'b0;
         ir_write_o   = 1'b0;
         pc_write_o   = 1'b0;
         pc_source_o  = 2'b00;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = 2'b00;
         alu_op_o     = 3'b000;
         reg_write_o  = 1'b0;
         reg_dst_o    = 2'b00;
         mem_to_reg_o = 2'b00;
         retire_o     = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
         illegal_c    = 1'b0;
`endif
      end
   end

   assign state_o = rst_i ? 4'd0 : state_q;
`ifdef MULTICYCLE_CTRL_TRAP_EN
   assign illegal_o = illegal_c;
`else
   assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for multicycle_ctrl: each row gives inputs and the full expected output word.
module tb_multicycle_ctrl;

   logic       clk, rst;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
   logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
   logic       alu_src_a, reg_write, retire, illegal;
   logic [2:0] alu_op;
   logic [3:0] state;

   multicycle_ctrl dut (
      .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct),
      .zero_i(zero), .mem_ready_i(mem_ready),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .i_or_d_o(i_or_d),
      .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_source_o(pc_source),
      .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
      .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
      .retire_o(retire), .state_o(state), .illegal_o(illegal)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic [1:0]  rdy;   // 0/1 literal, 2 = random (ready is a don't-care there)
      logic [23:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [23:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   localparam logic [1:0] N = 2'd0, Y = 2'd1, R = 2'd2;
   localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, BNE = 6'h05;
   localparam logic [5:0] J = 6'h02, JAL = 6'h03, ADDI = 6'h08, BAD = 6'h3F;

   // Output word: mr mw iod irw pcw pcs[2] sa sb[2] aop[3] rw rd[2] mtr[2] ret st[4] ill
   function automatic logic [23:0] ev(input logic mr, mw, iod, irw, pcw, input logic [1:0] pcs,
                                      input logic sa, input logic [1:0] sb, input logic [2:0] aop,
                                      input logic rw, input logic [1:0] rd, mtr,
                                      input logic ret, input logic [3:0] st, input logic ill);
      return {mr, mw, iod, irw, pcw, pcs, sa, sb, aop, rw, rd, mtr, ret, st, ill};
   endfunction

   logic [23:0] e_rst, e_fetch_w, e_fetch_r, e_decode, e_dec_ill, e_maddr, e_mrd, e_mwb;
   logic [23:0] e_mwr_w, e_mwr_r, e_rexec, e_rwb, e_br_t, e_br_n, e_j, e_jal, e_iex, e_iwb;
   logic [23:0] e_jr, e_trap;

   task automatic add_vec(input logic r, input logic [5:0] op, fn, input logic z,
                          input logic [1:0] rdy, input logic [23:0] e);
      vec_t v;
      v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
      vecs.push_back(v);
   endtask

   // driver: inputs change on the falling edge, expected word goes to the scoreboard
   task automatic drive(input vec_t v);
      @(negedge clk);
      rst    = v.rst;
      opcode = v.op;
      funct  = v.fn;
      zero   = v.z;
      mem_ready = (v.rdy == R) ? 1'($urandom_range(0, 1)) : v.rdy[0];
      exp_q.push_back(v.exp);
   endtask

   task automatic check(input string name);
      logic [23:0] act, exp;
      act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, alu_src_a, alu_src_b,
             alu_op, reg_write, reg_dst, mem_to_reg, retire, state, illegal};
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %06h expected %06h (state got %0d expected %0d)",
                  name, act, exp, act[4:1], exp[4:1]);
      end
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

      e_rst     = '0;
      e_fetch_w = ev(1,0,0,0,0,2'b00,0,2'b01,3'b000,0,2'b00,2'b00,0,4'd0,0);
      e_fetch_r = ev(1,0,0,1,1,2'b00,0,2'b01,3'b000,0,2'b00,2'b00,0,4'd0,0);
      e_decode  = ev(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,2'b00,2'b00,0,4'd1,0);
      e_dec_ill = ev(0,0,0,0,0,2'b00,0,2'b11,3'b000,0,2'b00,2'b00,1,4'd1,0);
      e_maddr   = ev(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,2'b00,2'b00,0,4'd2,0);
      e_mrd     = ev(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,0,4'd3,0);
      e_mwb     = ev(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,2'b00,2'b01,1,4'd4,0);
      e_mwr_w   = ev(0,1,1,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,0,4'd5,0);
      e_mwr_r   = ev(0,1,1,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,1,4'd5,0);
      e_rexec   = ev(0,0,0,0,0,2'b00,1,2'b00,3'b010,0,2'b00,2'b00,0,4'd6,0);
      e_rwb     = ev(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,2'b01,2'b00,1,4'd7,0);
      e_br_t    = ev(0,0,0,0,1,2'b01,1,2'b00,3'b001,0,2'b00,2'b00,1,4'd8,0);
      e_br_n    = ev(0,0,0,0,0,2'b01,1,2'b00,3'b001,0,2'b00,2'b00,1,4'd8,0);
      e_j       = ev(0,0,0,0,1,2'b10,0,2'b00,3'b000,0,2'b00,2'b00,1,4'd9,0);
      e_jal     = ev(0,0,0,0,1,2'b10,0,2'b00,3'b000,1,2'b10,2'b10,1,4'd9,0);
      e_iex     = ev(0,0,0,0,0,2'b00,1,2'b10,3'b000,0,2'b00,2'b00,0,4'd10,0);
      e_iwb     = ev(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,2'b00,2'b00,1,4'd11,0);
      e_jr      = ev(0,0,0,0,1,2'b11,0,2'b00,3'b000,0,2'b00,2'b00,1,4'd12,0);
      e_trap    = ev(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,0,4'd13,1);

      // reset state
      add_vec(1, RT, 0, 0, Y, e_rst);
      add_vec(1, RT, 0, 0, Y, e_rst);
      // lw, zero-wait: 5 cycles
      add_vec(0, LW, 0, 0, Y, e_fetch_r);
      add_vec(0, LW, 0, 0, R, e_decode);
      add_vec(0, LW, 0, 0, R, e_maddr);
      add_vec(0, LW, 0, 0, Y, e_mrd);
      add_vec(0, LW, 0, 0, R, e_mwb);
      // lw with fetch and read wait states
      add_vec(0, LW, 0, 0, N, e_fetch_w);
      add_vec(0, LW, 0, 0, Y, e_fetch_r);
      add_vec(0, LW, 0, 0, R, e_decode);
      add_vec(0, LW, 0, 0, R, e_maddr);
      add_vec(0, LW, 0, 0, N, e_mrd);
      add_vec(0, LW, 0, 0, N, e_mrd);
      add_vec(0, LW, 0, 0, Y, e_mrd);
      add_vec(0, LW, 0, 0, R, e_mwb);
      // sw with 3 write wait states
      add_vec(0, SW, 0, 0, Y, e_fetch_r);
      add_vec(0, SW, 0, 0, R, e_decode);
      add_vec(0, SW, 0, 0, R, e_maddr);
      for (int i = 0; i < 3; i++) add_vec(0, SW, 0, 0, N, e_mwr_w);
      add_vec(0, SW, 0, 0, Y, e_mwr_r);
      // branches, both conditions
      add_vec(0, BEQ, 0, 1, Y, e_fetch_r); add_vec(0, BEQ, 0, 1, R, e_decode); add_vec(0, BEQ, 0, 1, R, e_br_t);
      add_vec(0, BNE, 0, 1, Y, e_fetch_r); add_vec(0, BNE, 0, 1, R, e_decode); add_vec(0, BNE, 0, 1, R, e_br_n);
      add_vec(0, BEQ, 0, 0, Y, e_fetch_r); add_vec(0, BEQ, 0, 0, R, e_decode); add_vec(0, BEQ, 0, 0, R, e_br_n);
      add_vec(0, BNE, 0, 0, Y, e_fetch_r); add_vec(0, BNE, 0, 0, R, e_decode); add_vec(0, BNE, 0, 0, R, e_br_t);
      // R-type add, addi
      add_vec(0, RT, 6'h20, 0, Y, e_fetch_r); add_vec(0, RT, 6'h20, 0, R, e_decode);
      add_vec(0, RT, 6'h20, 0, R, e_rexec);   add_vec(0, RT, 6'h20, 0, R, e_rwb);
      add_vec(0, ADDI, 0, 0, Y, e_fetch_r); add_vec(0, ADDI, 0, 0, R, e_decode);
      add_vec(0, ADDI, 0, 0, R, e_iex);     add_vec(0, ADDI, 0, 0, R, e_iwb);
      // j, jal, jr
      add_vec(0, J, 0, 0, Y, e_fetch_r);   add_vec(0, J, 0, 0, R, e_decode);   add_vec(0, J, 0, 0, R, e_j);
      add_vec(0, JAL, 0, 0, Y, e_fetch_r); add_vec(0, JAL, 0, 0, R, e_decode); add_vec(0, JAL, 0, 0, R, e_jal);
      add_vec(0, RT, 6'h08, 0, Y, e_fetch_r); add_vec(0, RT, 6'h08, 0, R, e_decode); add_vec(0, RT, 6'h08, 0, R, e_jr);
      // reset while stalled in FETCH: ready high in the reset cycle must not load IR
      add_vec(0, LW, 0, 0, N, e_fetch_w);
      add_vec(1, LW, 0, 0, Y, e_rst);
      add_vec(0, LW, 0, 0, N, e_fetch_w);
      // reset during a stalled store aborts it
      add_vec(0, SW, 0, 0, Y, e_fetch_r);
      add_vec(0, SW, 0, 0, R, e_decode);
      add_vec(0, SW, 0, 0, R, e_maddr);
      add_vec(0, SW, 0, 0, N, e_mwr_w);
      add_vec(1, SW, 0, 0, Y, e_rst);
      add_vec(0, SW, 0, 0, N, e_fetch_w);
      // unsupported opcode
      add_vec(0, BAD, 0, 0, Y, e_fetch_r);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      add_vec(0, BAD, 0, 0, R, e_decode);
      for (int i = 0; i < 10; i++) add_vec(0, BAD, 0, 0, R, e_trap);
      add_vec(1, BAD, 0, 0, R, e_rst);
`else
      add_vec(0, BAD, 0, 0, R, e_dec_ill);
`endif
      add_vec(0, ADDI, 0, 0, Y, e_fetch_r);
      add_vec(0, ADDI, 0, 0, R, e_decode);
      add_vec(0, ADDI, 0, 0, R, e_iex);
      add_vec(0, ADDI, 0, 0, R, e_iwb);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #2;
         check($sformatf("row%0d", i));
      end

      // hand-written: long fetch stall with random opcodes never loads IR or moves
      for (int i = 0; i < 8; i++) begin
         vec_t v;
         v.rst = 1'b0; v.op = 6'($urandom_range(0, 63)); v.fn = 6'($urandom_range(0, 63));
         v.z = 1'($urandom_range(0, 1)); v.rdy = N; v.exp = e_fetch_w;
         drive(v);
         #2;
         check($sformatf("fetch_stall%0d", i));
      end

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer that lets one ALU and one unified instruction/data memory port serve every phase of MIPS instruction execution (fetch, decode, execute, memory, write-back). It sits beside the shared datapath: it reads the opcode/funct fields of the instruction register and the ALU zero flag, and drives every mux select, write enable and memory request in the datapath. Memory accesses use a ready handshake, so the controller stalls on slow memory.

## Interface
- No parameters.

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous reset, active-high
- opcode_i  in  6  instruction register [31:26]
- funct_i  in  6  instruction register [5:0]
- zero_i  in  1  ALU zero flag, combinational from current ALU operands
- mem_ready_i  in  1  memory completes current access this cycle
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  load PC (resolved; includes branch condition)
- pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs data
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  00 rt, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op_o  out  3  000 add, 001 sub, 010 decode funct
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- retire_o  out  1  one-cycle pulse in the last cycle of each instruction
- state_o  out  4  current state encoding
- illegal_o  out  1  unsupported opcode trapped (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JR=12, TRAP=13. Encodings 14–15 are unreachable. If reached, the next state is FETCH.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=add, pc_source=00. ir_write and pc_write assert only in the cycle mem_ready_i=1, which also moves the state to DECODE. Otherwise the state holds.
- DECODE: src_a=0, src_b=11, alu_op=add (branch target into ALUOut). Next state by opcode:
  - 0x23 lw / 0x2B sw → MEM_ADDR
  - 0x00 → JR if funct=0x08, else R_EXEC
  - 0x04 beq / 0x05 bne → BRANCH
  - 0x02 j / 0x03 jal → JUMP
  - 0x08 addi → I_EXEC
  - other → TRAP or FETCH (see Configuration)
- MEM_ADDR: src_a=1, src_b=10, add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Next is FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready_i, then goes to FETCH.
- R_EXEC: src_a=1, src_b=00, alu_op=010. Next is R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Next is FETCH.
- I_EXEC: src_a=1, src_b=10, add. Next is I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Next is FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_source=01. pc_write = zero_i for beq, ~zero_i for bne. Next is FETCH.
- JUMP: pc_write=1, pc_source=10. For jal, also reg_write=1, reg_dst=10, mem_to_reg=10. Next is FETCH.
- JR: pc_write=1, pc_source=11. Next is FETCH.
- Any output not listed for a state is 0.
- retire_o=1 in every state whose next state is FETCH. For MEM_WR this applies only in the mem_ready_i cycle.

## Timing
- The state register is the only storage. Outputs are combinational from the state, opcode_i, funct_i, zero_i and mem_ready_i.
- With rst_i=1 at an edge, the state becomes FETCH. While rst_i is high, all outputs are forced to 0 and state_o=0; this applies to every output.
- Reset mid-instruction, including during a stalled memory access, aborts the instruction. No write enable asserts in the reset cycle.
- With zero-wait memory (mem_ready_i held at 1), cycles per instruction are: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal 3, jr 3. Each memory wait cycle adds 1.
- mem_ready_i is ignored in states with no memory request.
- A request, once raised, stays asserted with a stable address select until the ready cycle.

## Configuration
- MULTICYCLE_CTRL_TRAP_EN defined:
  - An unsupported opcode moves DECODE → TRAP.
  - TRAP asserts illegal_o=1, drives all other outputs 0, and holds until rst_i. retire_o stays 0.
- MULTICYCLE_CTRL_TRAP_EN undefined:
  - An unsupported opcode moves DECODE → FETCH with retire_o=1 (executes as a NOP).
  - The TRAP state does not exist and illegal_o is tied to 0.

## Test plan
- lw (opcode 0x23) with mem_ready_i held at 1 → states 0,1,2,3,4. reg_write=1 with mem_to_reg=01 in cycle 5. retire_o pulses once.
- sw with mem_ready_i low for 3 cycles in MEM_WR → mem_write_o stays 1 for 4 cycles with i_or_d_o=1. The state advances only on ready.
- beq with zero_i=1, then bne with zero_i=1 → pc_write_o=1 in BRANCH for beq and 0 for bne. Each instruction takes 3 cycles.
- jal (opcode 0x03) → in JUMP: pc_write_o=1, pc_source_o=10, reg_dst_o=10, mem_to_reg_o=10. funct 0x08 under opcode 0 → JR state with pc_source_o=11.
- rst_i asserted while stalled in FETCH → the next cycle shows state_o=0, all outputs 0, and ir_write_o never pulses.
- Opcode 0x3F → with MULTICYCLE_CTRL_TRAP_EN: state_o=13, illegal_o=1, and it stays there across 10 cycles. Without the macro: back to FETCH with retire_o=1.
